// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the CAM subarray command sequencer.
//   - field widths for the command/response bus and subarray pins
//   - opcode encodings
//   - sequencer FSM state encoding
//   - is_search_op(): decodes the search opcodes 010..110
package cam_pkg;

  localparam int TAG_W      = 16;
  localparam int DATA_W     = 16;
  localparam int CMP_ADDR_W = 10;
  localparam int PPG_ADDR_W = 4;
  localparam int OP_W       = 3;
  localparam int CNT_W      = 4;

  localparam logic [OP_W-1:0] OP_WR_DIRECT = 3'b000;
  localparam logic [OP_W-1:0] OP_WR_UPDATE = 3'b001;
  localparam logic [OP_W-1:0] OP_SRCH_CMP  = 3'b010;
  localparam logic [OP_W-1:0] OP_SRCH_PPG  = 3'b011;
  localparam logic [OP_W-1:0] OP_SRCH_CMP2 = 3'b100;
  localparam logic [OP_W-1:0] OP_SRCH_PPG2 = 3'b101;
  localparam logic [OP_W-1:0] OP_SRCH_MIX  = 3'b110;
  localparam logic [OP_W-1:0] OP_ILLEGAL   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WDONE  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic is_search_op(input logic [OP_W-1:0] op);
    return (op >= OP_SRCH_CMP) && (op <= OP_SRCH_MIX);
  endfunction

endpackage

// File: rtl/cam_subarray_seq_if.sv
// cam_subarray_seq_if: command and response channels between the CAM
// dispatcher (master) and one subarray sequencer (slave).
//   cmd_*  : valid/ready command channel, master -> slave
//   rsp_*  : valid/ready response channel, slave -> master
interface cam_subarray_seq_if;
  import cam_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic                  cmd_addr_sel;
  logic [CMP_ADDR_W-1:0] cmd_cmp_addr;
  logic [PPG_ADDR_W-1:0] cmd_ppg_addr;
  logic [1:0]            cmd_cmp_data;
  logic [1:0]            cmd_ppg_data;
  logic [DATA_W-1:0]     cmd_data;
  logic [TAG_W-1:0]      cmd_tag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr_sel, cmd_cmp_addr, cmd_ppg_addr,
           cmd_cmp_data, cmd_ppg_data, cmd_data, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr_sel, cmd_cmp_addr, cmd_ppg_addr,
           cmd_cmp_data, cmd_ppg_data, cmd_data, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tag, rsp_err
  );

endinterface

// File: rtl/cam_subarray_seq.sv
// cam_subarray_seq: command-side initiator for one CAM subarray.
// Accepts one write/search command at a time, drives the subarray pins,
// paces the write (write_done pulse) or waits out search latency and
// captures tag_out, then returns one response.
//
// Ports:
//   CLK, rst          : clock, synchronous active-low reset
//   bus (slave)       : cmd_* command channel, rsp_* response channel
//   sa_*              : subarray control pins (registered command fields,
//                       chip_enable/write_done/update decoded from state)
//   sa_tag_out        : subarray match vector, sampled SEARCH_LAT cycles
//                       after the search op is driven
//   perf_search_cnt,
//   perf_hit_cnt      : saturating search/hit counters, present only when
//                       CAM_SEQ_PERF_CNT_EN is defined
//
// Latency accept -> rsp_valid: WRITE_CYCLES+2 (write), SEARCH_LAT+1
// (search), 1 (illegal opcode).
module cam_subarray_seq
  import cam_pkg::*;
#(
  parameter int WRITE_CYCLES = 2,
  parameter int SEARCH_LAT   = 2
) (
  input  logic                  CLK,
  input  logic                  rst,
  cam_subarray_seq_if.slave     bus,
  output logic                  sa_chip_enable,
  output logic [OP_W-1:0]       sa_operation_mode,
  output logic                  sa_addr_select,
  output logic                  sa_update_signal,
  output logic                  sa_write_done,
  output logic [CMP_ADDR_W-1:0] sa_cmp_addr,
  output logic [PPG_ADDR_W-1:0] sa_ppg_addr,
  output logic [1:0]            sa_cmp_data,
  output logic [1:0]            sa_ppg_data,
  output logic [DATA_W-1:0]     sa_data_in,
  output logic [TAG_W-1:0]      sa_tag_in,
  input  logic [TAG_W-1:0]      sa_tag_out
`ifdef CAM_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]           perf_search_cnt,
  output logic [15:0]           perf_hit_cnt
`endif
);

  generate
    if (WRITE_CYCLES < 1 || WRITE_CYCLES > 15) begin : g_bad_write_cycles
      $error("cam_subarray_seq: WRITE_CYCLES must be in 1..15");
    end
    if (SEARCH_LAT < 1 || SEARCH_LAT > 15) begin : g_bad_search_lat
      $error("cam_subarray_seq: SEARCH_LAT must be in 1..15");
    end
  endgenerate

  // The counter starts at 0 in the first cycle of the phase, so the
  // phase ends when it reaches N-1.
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SEARCH_LAT - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [OP_W-1:0]       r_op;
  logic                  r_addr_sel;
  logic                  r_update;
  logic [CMP_ADDR_W-1:0] r_cmp_addr;
  logic [PPG_ADDR_W-1:0] r_ppg_addr;
  logic [1:0]            r_cmp_data;
  logic [1:0]            r_ppg_data;
  logic [DATA_W-1:0]     r_data;
  logic [TAG_W-1:0]      r_tag;
  logic [TAG_W-1:0]      r_rsp_tag;
  logic                  r_rsp_err;

  logic w_cmd_ready, w_rsp_valid, w_accept, w_rsp_hs, w_capture;
  logic w_ce, w_wdone, w_upd;

  assign w_accept  = bus.cmd_valid & w_cmd_ready;
  assign w_rsp_hs  = w_rsp_valid & bus.rsp_ready;
  assign w_capture = (r_state == ST_SEARCH) && (r_cnt == S_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.cmd_op == OP_ILLEGAL)          w_state_nxt = ST_RESP;
          else if (is_search_op(bus.cmd_op))     w_state_nxt = ST_SEARCH;
          else                                   w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE:  if (r_cnt == W_LAST) w_state_nxt = ST_WDONE;
      ST_WDONE:  w_state_nxt = ST_RESP;
      ST_SEARCH: if (w_capture) w_state_nxt = ST_RESP;
      ST_RESP:   if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs. Enable/update/write_done come straight from
  // state so a reset mid-op drops them the cycle after rst is sampled.
  always_comb begin
    w_cmd_ready = (r_state == ST_IDLE);
    w_rsp_valid = (r_state == ST_RESP);
    w_ce        = (r_state == ST_WRITE) || (r_state == ST_WDONE) ||
                  (r_state == ST_SEARCH);
    w_wdone     = (r_state == ST_WDONE);
    w_upd       = r_update && ((r_state == ST_WRITE) || (r_state == ST_WDONE));
  end

  // Command field registers, phase counter and response capture
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_addr_sel <= 1'b0;
      r_update   <= 1'b0;
      r_cmp_addr <= '0;
      r_ppg_addr <= '0;
      r_cmp_data <= '0;
      r_ppg_data <= '0;
      r_data     <= '0;
      r_tag      <= '0;
      r_rsp_tag  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_rsp_tag <= '0;
        r_rsp_err <= (bus.cmd_op == OP_ILLEGAL);
        // An illegal op leaves the subarray pins exactly as they were.
        if (bus.cmd_op != OP_ILLEGAL) begin
          r_op       <= bus.cmd_op;
          r_addr_sel <= bus.cmd_addr_sel;
          r_update   <= (bus.cmd_op == OP_WR_UPDATE);
          r_cmp_addr <= bus.cmd_cmp_addr;
          r_ppg_addr <= bus.cmd_ppg_addr;
          r_cmp_data <= bus.cmd_cmp_data;
          r_ppg_data <= bus.cmd_ppg_data;
          r_data     <= bus.cmd_data;
          r_tag      <= bus.cmd_tag;
        end
      end else if ((r_state == ST_WRITE) || (r_state == ST_SEARCH)) begin
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) r_rsp_tag <= sa_tag_out;
    end
  end

`ifdef CAM_SEQ_PERF_CNT_EN
  logic [15:0] r_perf_search, r_perf_hit;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_perf_search <= '0;
      r_perf_hit    <= '0;
    end else if (w_capture) begin
      if (r_perf_search != 16'hFFFF) r_perf_search <= r_perf_search + 16'd1;
      if ((sa_tag_out != '0) && (r_perf_hit != 16'hFFFF))
        r_perf_hit <= r_perf_hit + 16'd1;
    end
  end

  assign perf_search_cnt = r_perf_search;
  assign perf_hit_cnt    = r_perf_hit;
`endif

  assign bus.cmd_ready     = w_cmd_ready;
  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.rsp_tag       = r_rsp_tag;
  assign bus.rsp_err       = r_rsp_err;

  assign sa_chip_enable    = w_ce;
  assign sa_write_done     = w_wdone;
  assign sa_update_signal  = w_upd;
  assign sa_operation_mode = r_op;
  assign sa_addr_select    = r_addr_sel;
  assign sa_cmp_addr       = r_cmp_addr;
  assign sa_ppg_addr       = r_ppg_addr;
  assign sa_cmp_data       = r_cmp_data;
  assign sa_ppg_data       = r_ppg_data;
  assign sa_data_in        = r_data;
  assign sa_tag_in         = r_tag;

endmodule

// File: tb/tb_cam_subarray_seq.sv
// tb_cam_subarray_seq: self-checking bench for cam_subarray_seq with the
// default parameters (WRITE_CYCLES=2, SEARCH_LAT=2). Expected responses
// are queued when a command is sent and compared on each response
// handshake. A tiny subarray model returns model_tag while a search op is
// being driven and 0 otherwise.
module tb_cam_subarray_seq;
  import cam_pkg::*;

  localparam int WC = 2;
  localparam int SL = 2;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        sa_chip_enable, sa_addr_select, sa_update_signal, sa_write_done;
  logic [2:0]  sa_operation_mode;
  logic [9:0]  sa_cmp_addr;
  logic [3:0]  sa_ppg_addr;
  logic [1:0]  sa_cmp_data, sa_ppg_data;
  logic [15:0] sa_data_in, sa_tag_in, sa_tag_out;
  logic [15:0] model_tag = 16'h0;
`ifdef CAM_SEQ_PERF_CNT_EN
  logic [15:0] perf_search_cnt, perf_hit_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];   // {err, tag}

  cam_subarray_seq_if bus();

  cam_subarray_seq #(.WRITE_CYCLES(WC), .SEARCH_LAT(SL)) dut (
    .CLK(CLK), .rst(rst), .bus(bus),
    .sa_chip_enable(sa_chip_enable), .sa_operation_mode(sa_operation_mode),
    .sa_addr_select(sa_addr_select), .sa_update_signal(sa_update_signal),
    .sa_write_done(sa_write_done), .sa_cmp_addr(sa_cmp_addr),
    .sa_ppg_addr(sa_ppg_addr), .sa_cmp_data(sa_cmp_data),
    .sa_ppg_data(sa_ppg_data), .sa_data_in(sa_data_in),
    .sa_tag_in(sa_tag_in), .sa_tag_out(sa_tag_out)
`ifdef CAM_SEQ_PERF_CNT_EN
    , .perf_search_cnt(perf_search_cnt), .perf_hit_cnt(perf_hit_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  always_comb begin
    sa_tag_out = 16'h0;
    if (sa_chip_enable && sa_operation_mode >= 3'd2 && sa_operation_mode <= 3'd6)
      sa_tag_out = model_tag;
  end

  // Scoreboard: compare every response handshake against the queue head.
  always @(posedge CLK) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      logic [16:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got err=%0b tag=%h required none",
                 bus.rsp_err, bus.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rsp_err, bus.rsp_tag} !== e) begin
          failures++;
          $display("FAIL rsp_data got err=%0b tag=%h required err=%0b tag=%h",
                   bus.rsp_err, bus.rsp_tag, e[16], e[15:0]);
        end
      end
    end
  end

  task automatic drive_idle();
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr_sel = 0;
    bus.cmd_cmp_addr = 0; bus.cmd_ppg_addr = 0; bus.cmd_cmp_data = 0;
    bus.cmd_ppg_data = 0; bus.cmd_data = 0; bus.cmd_tag = 0;
    bus.rsp_ready = 1;
  endtask

  // Offer a command at a negedge, wait for acceptance, drop valid at the
  // first negedge after the accepting edge (cycle 1) and return there.
  task automatic send_cmd(input logic [2:0] op, input logic asel,
                          input logic [9:0] caddr, input logic [3:0] paddr,
                          input logic [15:0] data, input logic [15:0] tag);
    bit ok = 0;
    @(negedge CLK);
    bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_addr_sel = asel;
    bus.cmd_cmp_addr = caddr; bus.cmd_ppg_addr = paddr;
    bus.cmd_cmp_data = 2'b01; bus.cmd_ppg_data = 2'b10;
    bus.cmd_data = data; bus.cmd_tag = tag;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1; @(posedge CLK); break; end
      @(negedge CLK);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout op=%0d", op);
    end
    @(negedge CLK);
    bus.cmd_valid = 0;
  endtask

  // From cycle 1, count enable/write_done/update cycles until rsp_valid.
  task automatic wait_rsp(output int lat, output int ce, output int wd,
                          output int upd);
    lat = -1; ce = 0; wd = 0; upd = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge CLK);
      if (bus.rsp_valid) begin lat = k; break; end
      ce  += int'(sa_chip_enable);
      wd  += int'(sa_write_done);
      upd += int'(sa_update_signal);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK); rst = 1;
    @(negedge CLK);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got ready=%0b valid=%0b required 1 0",
               bus.cmd_ready, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_tag, bus.rsp_err} !== 17'h0) begin
      failures++;
      $display("FAIL reset_rsp got tag=%h err=%0b required 0", bus.rsp_tag, bus.rsp_err);
    end
    checks++;
    if ({sa_chip_enable, sa_operation_mode, sa_addr_select, sa_update_signal,
         sa_write_done, sa_cmp_addr, sa_ppg_addr, sa_cmp_data, sa_ppg_data,
         sa_data_in, sa_tag_in} !== 57'h0) begin
      failures++;
      $display("FAIL reset_sa got ce=%0b data=%h tag=%h required all zero",
               sa_chip_enable, sa_data_in, sa_tag_in);
    end
  endtask

  task automatic test_direct_write();
    int lat, ce, wd, upd;
    exp_q.push_back({1'b0, 16'h0});
    send_cmd(OP_WR_DIRECT, 1'b1, 10'h155, 4'h3, 16'hFFFF, 16'h1234);
    checks++;
    if (sa_data_in !== 16'hFFFF || sa_addr_select !== 1'b1 || sa_operation_mode !== 3'd0) begin
      failures++;
      $display("FAIL wr_fields got data=%h asel=%0b mode=%0d required FFFF 1 0",
               sa_data_in, sa_addr_select, sa_operation_mode);
    end
    wait_rsp(lat, ce, wd, upd);
    checks++;
    if (lat != WC + 2) begin failures++; $display("FAIL wr_latency got %0d required %0d", lat, WC + 2); end
    checks++;
    if (ce != WC + 1) begin failures++; $display("FAIL wr_ce_cycles got %0d required %0d", ce, WC + 1); end
    checks++;
    if (wd != 1) begin failures++; $display("FAIL wr_done_pulses got %0d required 1", wd); end
    checks++;
    if (upd != 0) begin failures++; $display("FAIL wr_update got %0d required 0", upd); end
    @(negedge CLK);
  endtask

  task automatic test_search(input logic [2:0] op, input logic [15:0] tag);
    int lat, ce, wd, upd;
    model_tag = tag;
    exp_q.push_back({1'b0, tag});
    send_cmd(op, 1'b0, 10'h2A, 4'b0100, 16'h0F0F, 16'h0);
    checks++;
    if (sa_ppg_addr !== 4'b0100 || sa_operation_mode !== op) begin
      failures++;
      $display("FAIL srch_fields got ppg=%h mode=%0d required 4 %0d",
               sa_ppg_addr, sa_operation_mode, op);
    end
    wait_rsp(lat, ce, wd, upd);
    checks++;
    if (lat != SL + 1) begin failures++; $display("FAIL srch_latency got %0d required %0d", lat, SL + 1); end
    checks++;
    if (upd != 0 || wd != 0) begin
      failures++; $display("FAIL srch_pins got upd=%0d wd=%0d required 0 0", upd, wd);
    end
    checks++;
    if (sa_chip_enable !== 1'b0) begin failures++; $display("FAIL srch_ce_drop got 1 required 0"); end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    int lat, ce, wd, upd;
    model_tag = 16'h5A3C;
    bus.rsp_ready = 0;
    exp_q.push_back({1'b0, 16'h5A3C});
    send_cmd(OP_SRCH_MIX, 1'b0, 10'h3, 4'b0100, 16'h0, 16'h0);
    wait_rsp(lat, ce, wd, upd);
    model_tag = 16'h0;
    bus.cmd_valid = 1; bus.cmd_op = OP_WR_UPDATE; bus.cmd_data = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 16'h5A3C || bus.cmd_ready !== 1'b0 ||
          sa_chip_enable !== 1'b0 || sa_data_in === 16'hBEEF) begin
        failures++;
        $display("FAIL bp_hold got valid=%0b tag=%h ready=%0b ce=%0b required 1 5a3c 0 0",
                 bus.rsp_valid, bus.rsp_tag, bus.cmd_ready, sa_chip_enable);
      end
    end
    bus.rsp_ready = 1; bus.cmd_valid = 0;
    @(negedge CLK);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got valid=%0b ready=%0b required 0 1",
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_illegal();
    int lat, ce, wd, upd;
    exp_q.push_back({1'b1, 16'h0});
    send_cmd(OP_ILLEGAL, 1'b1, 10'h3FF, 4'hF, 16'h1111, 16'h2222);
    wait_rsp(lat, ce, wd, upd);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL ill_latency got %0d required 1", lat); end
    checks++;
    if (sa_chip_enable !== 1'b0 || sa_data_in === 16'h1111) begin
      failures++;
      $display("FAIL ill_touch got ce=%0b data=%h required ce 0, data untouched",
               sa_chip_enable, sa_data_in);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_write();
    int lat, ce, wd, upd, bad_wd, bad_rsp;
    bad_wd = 0; bad_rsp = 0;
    send_cmd(OP_WR_DIRECT, 1'b0, 10'h1, 4'h1, 16'hC0DE, 16'h0);
    rst = 0;                       // cycle 1 of WRITE
    @(negedge CLK); rst = 1;
    checks++;
    if (sa_chip_enable !== 1'b0 || sa_data_in !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_clear got ce=%0b data=%h required 0 0", sa_chip_enable, sa_data_in);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      bad_wd  += int'(sa_write_done);
      bad_rsp += int'(bus.rsp_valid);
    end
    checks++;
    if (bad_wd != 0 || bad_rsp != 0) begin
      failures++;
      $display("FAIL rst_mid_abort got wd=%0d rsp=%0d required 0 0", bad_wd, bad_rsp);
    end
    exp_q.push_back({1'b0, 16'h0});
    send_cmd(OP_WR_UPDATE, 1'b0, 10'h2, 4'h2, 16'h7777, 16'hAAAA);
    checks++;
    if (sa_tag_in !== 16'hAAAA) begin
      failures++; $display("FAIL upd_tag got %h required aaaa", sa_tag_in);
    end
    wait_rsp(lat, ce, wd, upd);
    checks++;
    if (lat != WC + 2 || wd != 1 || upd != WC + 1) begin
      failures++;
      $display("FAIL upd_write got lat=%0d wd=%0d upd=%0d required %0d 1 %0d",
               lat, wd, upd, WC + 2, WC + 1);
    end
    @(negedge CLK);
    checks++;
    if (sa_update_signal !== 1'b0) begin failures++; $display("FAIL upd_drop got 1 required 0"); end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_search(OP_SRCH_PPG, 16'hAAAA);
    test_search(OP_SRCH_CMP, 16'h0000);
    test_search(OP_SRCH_CMP2, 16'h8001);
    test_backpressure();
    test_illegal();
    test_reset_mid_write();
    repeat (3) @(negedge CLK);
`ifdef CAM_SEQ_PERF_CNT_EN
    checks++;
    if (perf_search_cnt !== 16'd0 || perf_hit_cnt !== 16'd0) begin
      failures++;
      $display("FAIL perf_after_reset got %0d %0d required 0 0", perf_search_cnt, perf_hit_cnt);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rsp_missing got %0d outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
